// File: rtl/pin_entry_keypad.sv
// rtl/pin_entry_keypad.sv - two-digit BCD PIN entry front end with alarm lock.
// Optional idle-timeout on partial entries is built when PIN_TIMEOUT_EN is defined.
module pin_entry_keypad #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       alarma_bloqueo,
   output logic [7:0] pin,
   output logic       pin_validation,
   output logic       entry_error,
   output logic [1:0] digit_count,
   output logic       keypad_locked
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ONE    = 3'd1,
      S_TWO    = 3'd2,
      S_SUBMIT = 3'd3,
      S_LOCKED = 3'd4
   } state_t;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;

   state_t     state, state_d;
   logic [7:0] pin_d;
   logic       err_d;
   logic       pv_d;
   logic [1:0] dc_d;
   logic       lock_d;
   logic       timeout_hit;
   logic       entering;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("pin_entry_keypad: TIMEOUT_CYCLES must be at least 2");
   end

   assign entering = (state == S_IDLE) || (state == S_ONE) || (state == S_TWO);

`ifdef PIN_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] idle_cnt, idle_cnt_d;

   assign timeout_hit = (idle_cnt == CW'(TIMEOUT_CYCLES));

   // Counts only quiet cycles of a partial entry; anything else restarts it.
   always_comb begin
      idle_cnt_d = '0;
      if ((state == S_ONE || state == S_TWO) && !key_valid && !alarma_bloqueo && !timeout_hit)
         idle_cnt_d = idle_cnt + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) idle_cnt <= '0;
      else       idle_cnt <= idle_cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_IDLE;
         pin            <= 8'h00;
         pin_validation <= 1'b0;
         entry_error    <= 1'b0;
         digit_count    <= 2'd0;
         keypad_locked  <= 1'b0;
      end else begin
         state          <= state_d;
         pin            <= pin_d;
         pin_validation <= pv_d;
         entry_error    <= err_d;
         digit_count    <= dc_d;
         keypad_locked  <= lock_d;
      end
   end

   always_comb begin
      state_d = state;
      if (alarma_bloqueo) begin
         state_d = S_LOCKED;
      end else begin
         case (state)
            S_LOCKED, S_SUBMIT: state_d = S_IDLE;
            S_IDLE, S_ONE, S_TWO: begin
               if (timeout_hit) begin
                  state_d = S_IDLE;
               end else if (key_valid) begin
                  if (key_code <= 4'd9) begin
                     if (state == S_IDLE)     state_d = S_ONE;
                     else if (state == S_ONE) state_d = S_TWO;
                  end else if (key_code == KEY_CLEAR) begin
                     state_d = S_IDLE;
                  end else if (key_code == KEY_ENTER && state == S_TWO) begin
                     state_d = S_SUBMIT;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are computed from the next state so every port comes straight from a flop.
   always_comb begin
      pin_d  = pin;
      err_d  = 1'b0;
      pv_d   = (state_d == S_SUBMIT);
      lock_d = (state_d == S_LOCKED);
      case (state_d)
         S_ONE:   dc_d = 2'd1;
         S_TWO:   dc_d = 2'd2;
         default: dc_d = 2'd0;
      endcase
      if (alarma_bloqueo) begin
         pin_d = 8'h00;
      end else if (entering) begin
         if (timeout_hit) begin
            pin_d = 8'h00;
            err_d = 1'b1;
         end else if (key_valid) begin
            if (key_code <= 4'd9) begin
               if (state == S_IDLE)     pin_d = {key_code, 4'h0};
               else if (state == S_ONE) pin_d = {pin[7:4], key_code};
               else                     err_d = 1'b1;
            end else if (key_code == KEY_CLEAR) begin
               pin_d = 8'h00;
            end else if (key_code == KEY_ENTER) begin
               err_d = (state != S_TWO);
            end else begin
               err_d = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pin_entry_keypad.sv
// tb/tb_pin_entry_keypad.sv - directed and randomized checks against a digit-list model.
module tb_pin_entry_keypad;
   localparam int TMO = 10;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'h0;
   logic       alarma_bloqueo = 1'b0;
   logic [7:0] pin;
   logic       pin_validation;
   logic       entry_error;
   logic [1:0] digit_count;
   logic       keypad_locked;

   int errors = 0;
   int checks = 0;
   bit run = 0;

   always #5 clock = ~clock;

   pin_entry_keypad #(.TIMEOUT_CYCLES(TMO)) dut (
      .clock          (clock),
      .reset          (reset),
      .key_valid      (key_valid),
      .key_code       (key_code),
      .alarma_bloqueo (alarma_bloqueo),
      .pin            (pin),
      .pin_validation (pin_validation),
      .entry_error    (entry_error),
      .digit_count    (digit_count),
      .keypad_locked  (keypad_locked)
   );

   // Model: a list of held digits, a submit flag, a lock flag and a quiet-cycle count.
   int         ndig = 0;
   logic [3:0] dg [2];
   bit         m_sub = 0;
   bit         m_lock = 0;
   bit         m_err = 0;
   int         quiet = 0;
   int         quiet_next;
   bit         hit;

   initial begin
      dg[0] = 4'h0;
      dg[1] = 4'h0;
   end

   always @(posedge clock) begin
      hit = 0;
`ifdef PIN_TIMEOUT_EN
      hit = (quiet == TMO);
`endif
      if (reset) begin
         ndig = 0; dg[0] = 4'h0; dg[1] = 4'h0;
         m_sub = 0; m_lock = 0; m_err = 0; quiet = 0;
      end else begin
         quiet_next = (ndig > 0 && !key_valid) ? quiet + 1 : 0;
         m_err = 0;
         if (alarma_bloqueo) begin
            m_lock = 1; m_sub = 0; ndig = 0; dg[0] = 4'h0; dg[1] = 4'h0; quiet_next = 0;
         end else if (m_lock) begin
            m_lock = 0;
         end else if (hit) begin
            ndig = 0; dg[0] = 4'h0; dg[1] = 4'h0; m_err = 1; quiet_next = 0;
         end else if (m_sub) begin
            m_sub = 0;
         end else if (key_valid) begin
            if (key_code <= 4'd9) begin
               if (ndig == 2) m_err = 1;
               else begin
                  if (ndig == 0) dg[1] = 4'h0;
                  dg[ndig] = key_code;
                  ndig++;
               end
            end else if (key_code == 4'hA) begin
               ndig = 0; dg[0] = 4'h0; dg[1] = 4'h0;
            end else if (key_code == 4'hB) begin
               if (ndig == 2) begin m_sub = 1; ndig = 0; end
               else m_err = 1;
            end else begin
               m_err = 1;
            end
         end
         quiet = quiet_next;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (run) begin
         chk("pin", {24'h0, pin}, {24'h0, dg[0], dg[1]});
         chk("pin_validation", {31'h0, pin_validation}, {31'h0, m_sub});
         chk("entry_error", {31'h0, entry_error}, {31'h0, m_err});
         chk("digit_count", {30'h0, digit_count}, ndig);
         chk("keypad_locked", {31'h0, keypad_locked}, {31'h0, m_lock});
      end
   end

   task automatic step(input bit kv, input logic [3:0] c, input bit al, input bit rs);
      @(negedge clock);
      key_valid = kv; key_code = c; alarma_bloqueo = al; reset = rs;
   endtask

   task automatic key(input logic [3:0] c);
      step(1'b1, c, 1'b0, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   int r;
   int alarm_left = 0;
   int gap_left = 0;
   bit kv, al, rs;
   logic [3:0] c;

   initial begin
      repeat (2) @(negedge clock);
      run = 1;
      chk("rst_pin", {24'h0, pin}, 32'h00);
      chk("rst_dc", {30'h0, digit_count}, 32'd0);
      chk("rst_lock", {31'h0, keypad_locked}, 32'd0);
      idle();

      key(4'h4); key(4'h7);
      chk("t1_dc1", {30'h0, digit_count}, 32'd1);
      key(4'hB);
      chk("t1_dc2", {30'h0, digit_count}, 32'd2);
      idle();
      chk("t1_pv", {31'h0, pin_validation}, 32'd1);
      chk("t1_pin", {24'h0, pin}, 32'h47);
      chk("model_pin47", {24'h0, dg[0], dg[1]}, 32'h47);
      idle();
      chk("t1_pv_end", {31'h0, pin_validation}, 32'd0);

      key(4'h3); key(4'hB); idle();
      chk("t2_err", {31'h0, entry_error}, 32'd1);
      chk("t2_pin", {24'h0, pin}, 32'h30);
      chk("t2_dc", {30'h0, digit_count}, 32'd1);
      key(4'h9); key(4'hB); idle();
      chk("t2_pv", {31'h0, pin_validation}, 32'd1);
      chk("t2_pin39", {24'h0, pin}, 32'h39);

      key(4'h1); key(4'h2); key(4'h5); idle();
      chk("t3_err", {31'h0, entry_error}, 32'd1);
      chk("t3_pin", {24'h0, pin}, 32'h12);
      key(4'hA); idle();
      chk("t3_clr", {24'h0, pin}, 32'h00);
      chk("t3_dc", {30'h0, digit_count}, 32'd0);
      key(4'hE); idle();
      chk("t3_inv", {31'h0, entry_error}, 32'd1);

      key(4'h6);
      step(1'b1, 4'h8, 1'b1, 1'b0);
      step(1'b1, 4'hB, 1'b1, 1'b0);
      repeat (3) step(1'b0, 4'h0, 1'b1, 1'b0);
      chk("t4_lock", {31'h0, keypad_locked}, 32'd1);
      chk("t4_pin", {24'h0, pin}, 32'h00);
      chk("t4_pv", {31'h0, pin_validation}, 32'd0);
      idle(); idle();
      chk("t4_unlock", {31'h0, keypad_locked}, 32'd0);
      key(4'h5); idle();
      chk("t4_pin50", {24'h0, pin}, 32'h50);
      key(4'hA);

`ifdef PIN_TIMEOUT_EN
      key(4'h2);
      repeat (TMO + 1) idle();
      chk("t5_pre", {31'h0, entry_error}, 32'd0);
      idle();
      chk("t5_err", {31'h0, entry_error}, 32'd1);
      chk("t5_pin", {24'h0, pin}, 32'h00);
      key(4'h2);
      repeat (TMO - 1) idle();
      key(4'h3);
      repeat (TMO) idle();
      chk("t5_restart", {30'h0, digit_count}, 32'd2);
      key(4'hA);
`else
      key(4'h2);
      repeat (3 * TMO) idle();
      chk("t5_hold", {30'h0, digit_count}, 32'd1);
      chk("t5_pin", {24'h0, pin}, 32'h20);
      key(4'hA);
`endif

      key(4'h1); key(4'h2); key(4'hB);
      step(1'b0, 4'h0, 1'b0, 1'b1);
      chk("t6_pv", {31'h0, pin_validation}, 32'd1);
      idle();
      chk("t6_pv_rst", {31'h0, pin_validation}, 32'd0);
      chk("t6_pin_rst", {24'h0, pin}, 32'h00);

      for (int i = 0; i < 4000; i++) begin
         if (alarm_left > 0) alarm_left--;
         else if ($urandom_range(0, 199) == 0) alarm_left = $urandom_range(1, 6);
         if (gap_left > 0) gap_left--;
         else if ($urandom_range(0, 59) == 0) gap_left = $urandom_range(TMO - 2, TMO + 3);
         rs = ($urandom_range(0, 399) == 0);
         al = (alarm_left > 0);
         kv = (gap_left == 0) && ($urandom_range(0, 2) != 0);
         r = $urandom_range(0, 99);
         if (r < 60)      c = 4'($urandom_range(0, 9));
         else if (r < 75) c = 4'hB;
         else if (r < 85) c = 4'hA;
         else             c = 4'($urandom_range(12, 15));
         step(kv, c, al, rs);
      end
      idle(); idle();
      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
